param_reg_file: RTL and testbench

//  Parametrised multi-port register file; next generation of the 8x8 two-read/one-write datapath file.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scan.sv | 41 ++++
 rtl/param_reg_file.sv | 117 +++++++++++
 tb/tb_param_reg_file.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scan.sv
// Debug auto-scan: steps dbg_addr once every SCAN_DIV clocks while enabled.
module regfile_scan
  import regfile_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25_000_000,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_step
);

  localparam int unsigned DIV_W = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;

  // Divider wraps at SCAN_DIV-1; the wrap advances the address and pulses dbg_step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      dbg_addr <= '0;
      dbg_step <= 1'b0;
    end else if (scan_en) begin
      if (div == DIV_LAST) begin
        div      <= '0;
        dbg_addr <= dbg_addr + ADDR_W'(1);
        dbg_step <= 1'b1;
      end else begin
        div      <= div + DIV_W'(1);
        dbg_step <= 1'b0;
      end
    end else begin
      div      <= '0;
      dbg_step <= 1'b0;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Multi-port register file: two combinational reads, one write, optional
// hardwired R0 and bypass, sequential bulk clear, and a debug scan port.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned SCAN_DIV = 25_000_000,
  localparam int unsigned ADDR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              clr_req,
  output logic              busy,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              dbg_step
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              wr_en_c;
  logic              clr_en_c;

  // State register; busy tracks the state being entered so it is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      busy  <= (state_nxt == CLEAR);
    end
  end

  // Next-state: a clear sweep visits every entry once, then returns to IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == PTR_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes are dropped (not queued) during a sweep; R0 writes vanish when hardwired.
  always_comb begin
    wr_en_c  = 1'b0;
    clr_en_c = 1'b0;
    if (state == CLEAR) begin
      clr_en_c = 1'b1;
    end else if (we3 && !((ZERO_REG != 0) && (wa3 == '0))) begin
      wr_en_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clr_en_c) begin
      mem[ptr] <= '0;
    end else if (wr_en_c) begin
      mem[wa3] <= wd3;
    end
  end

  // Read muxes; wr_en_c is already low during a sweep, which suppresses bypass there.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
    if ((BYPASS != 0) && wr_en_c && (ra1 == wa3)) rd1 = wd3;
    if ((BYPASS != 0) && wr_en_c && (ra2 == wa3)) rd2 = wd3;
  end

  always_comb begin
    dbg_data = mem[dbg_addr];
    if ((ZERO_REG != 0) && (dbg_addr == '0)) dbg_data = '0;
  end

  regfile_scan #(
    .SCAN_DIV (SCAN_DIV),
    .ADDR_W   (ADDR_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .dbg_addr (dbg_addr),
    .dbg_step (dbg_step)
  );

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench: two instances (R0 hardwired/no bypass, plain R0/bypass)
// share stimulus and are compared against a behavioural model every cycle.
module tb_param_reg_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we3;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic [2:0] ra1, ra2;
  logic       clr_req;
  logic       scan_en;

  logic [7:0] rd1_a, rd2_a, dbg_data_a, rd1_b, rd2_b, dbg_data_b;
  logic       busy_a, busy_b, dbg_step_a, dbg_step_b;
  logic [2:0] dbg_addr_a, dbg_addr_b;

  param_reg_file #(.ZERO_REG(1), .BYPASS(0), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .clr_req(clr_req), .busy(busy_a), .scan_en(scan_en),
    .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a), .dbg_step(dbg_step_a)
  );

  param_reg_file #(.ZERO_REG(0), .BYPASS(1), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .clr_req(clr_req), .busy(busy_b), .scan_en(scan_en),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b), .dbg_step(dbg_step_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a1, a2, da, b1, b2, db;
    logic       busy;
    logic [2:0] dbg;
    logic       step;
  } exp_t;

  exp_t sb[$];

  logic [7:0] ma [8];
  logic [7:0] mb [8];
  bit         m_busy;
  int         m_ptr;
  int         m_div;
  logic [2:0] m_dbg;
  bit         m_step;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    m_busy = 0; m_ptr = 0; m_div = 0; m_dbg = 3'd0; m_step = 0;
  endtask

  function automatic logic [7:0] exp_a(input logic [2:0] ra);
    return (ra == 3'd0) ? 8'h00 : ma[ra];
  endfunction

  function automatic logic [7:0] exp_b(input logic [2:0] ra);
    return (we3 && !m_busy && ra == wa3) ? wd3 : mb[ra];
  endfunction

  task automatic model_edge();
    if (!m_busy) begin
      if (we3) begin
        if (wa3 != 3'd0) ma[wa3] = wd3;
        mb[wa3] = wd3;
      end
      if (clr_req) begin
        m_busy = 1;
        m_ptr  = 0;
      end
    end else begin
      ma[m_ptr] = 8'h00;
      mb[m_ptr] = 8'h00;
      if (m_ptr == 7) m_busy = 0;
      m_ptr++;
    end
    if (scan_en) begin
      if (m_div == 3) begin
        m_div = 0; m_dbg = m_dbg + 3'd1; m_step = 1;
      end else begin
        m_div++; m_step = 0;
      end
    end else begin
      m_div = 0; m_step = 0;
    end
  endtask

  // Push the expectation for the driven inputs, compare at negedge, advance model at posedge.
  task automatic cycle();
    exp_t e;
    e.a1 = exp_a(ra1); e.a2 = exp_a(ra2); e.da = exp_a(m_dbg);
    e.b1 = exp_b(ra1); e.b2 = exp_b(ra2); e.db = mb[m_dbg];
    e.busy = m_busy; e.dbg = m_dbg; e.step = m_step;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("rd1_a", rd1_a, e.a1);
    check("rd2_a", rd2_a, e.a2);
    check("rd1_b", rd1_b, e.b1);
    check("rd2_b", rd2_b, e.b2);
    check("busy_a", busy_a, e.busy);
    check("busy_b", busy_b, e.busy);
    check("dbg_addr", dbg_addr_a, e.dbg);
    check("dbg_step", dbg_step_a, e.step);
    check("dbg_data_a", dbg_data_a, e.da);
    check("dbg_data_b", dbg_data_b, e.db);
    if (busy_a) busy_cnt++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit we, input int wa, input int wd,
                       input int r1, input int r2, input bit clr);
    we3 = we; wa3 = 3'(wa); wd3 = 8'(wd);
    ra1 = 3'(r1); ra2 = 3'(r2); clr_req = clr;
    cycle();
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) drive(0, 0, 0, i, 7 - i, 0);
  endtask

  initial begin
    rst_n = 1'b0; we3 = 0; wa3 = 0; wd3 = 0; ra1 = 0; ra2 = 0;
    clr_req = 0; scan_en = 0;
    model_reset();
    #12;
    check("rst_busy", busy_a, 1'b0);
    check("rst_dbg_addr", dbg_addr_b, 3'd0);
    check("rst_dbg_step", dbg_step_b, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_all();

    // Write R3 then read: bypass instance sees it in the write cycle.
    drive(1, 3, 'hA5, 3, 3, 0);
    drive(0, 0, 0, 3, 3, 0);

    // R0 write: hardwired instance keeps 0, plain instance stores FF.
    drive(1, 0, 'hFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Fill R1..R7, sweep with a dropped mid-sweep write to R5.
    for (int i = 1; i < 8; i++) drive(1, i, 'h11 * i, i, 0, 0);
    busy_cnt = 0;
    drive(0, 0, 0, 1, 2, 1);
    for (int i = 0; i < 8; i++) drive(i == 3, 5, 'h55, 5, i, 0);
    drive(0, 0, 0, 5, 0, 0);
    check("busy_len", busy_cnt, 8);
    read_all();

    // Write and clear on the same edge: write lands, then gets swept.
    drive(1, 2, 'h22, 2, 3, 1);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 2, 0, 0);
    read_all();

    // Reset in the middle of a sweep.
    for (int i = 1; i < 8; i++) drive(1, i, 'h10 + i, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 4, 6, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_busy_a", busy_a, 1'b0);
    check("midrst_busy_b", busy_b, 1'b0);
    check("midrst_r6", rd2_b, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 4, 'h44, 4, 4, 0);
    read_all();

    // Random traffic without clears.
    for (int i = 0; i < 30; i++)
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255),
            $urandom_range(0, 7), $urandom_range(0, 7), 0);

    // Debug scan: full wrap of the address, then hold with scan disabled.
    for (int i = 1; i < 8; i++) drive(1, i, 'hC0 + i, 0, 0, 0);
    scan_en = 1'b1;
    for (int i = 0; i < 40; i++) drive(0, 0, 0, i % 8, 0, 0);
    scan_en = 1'b0;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
